// File: rtl/color_classifier_pkg.sv
// Shared definitions for the colour classifier.
//  - COL_* : colour codes, also consumed by downstream track/marker logic
//  - cc_state_t : classifier sequencing states
//  - classify() : priority classification of one mapped RGB triplet
package color_classifier_pkg;

    localparam logic [2:0] COL_UNKNOWN = 3'd0;
    localparam logic [2:0] COL_RED     = 3'd1;
    localparam logic [2:0] COL_GREEN   = 3'd2;
    localparam logic [2:0] COL_BLUE    = 3'd3;
    localparam logic [2:0] COL_WHITE   = 3'd4;
    localparam logic [2:0] COL_BLACK   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SUM,
        ST_CLASSIFY,
        ST_UPDATE
    } cc_state_t;

    // Margin compares are widened to 11 bits so channel + margin cannot wrap.
    function automatic logic [2:0] classify(
        input logic [9:0]  r,
        input logic [9:0]  g,
        input logic [9:0]  b,
        input logic [11:0] total,
        input logic [11:0] dark_thresh,
        input logic [11:0] white_thresh,
        input logic [9:0]  margin
    );
        logic [10:0] r11, g11, b11, m11;
        r11 = {1'b0, r};
        g11 = {1'b0, g};
        b11 = {1'b0, b};
        m11 = {1'b0, margin};
        if (total < dark_thresh)
            return COL_BLACK;
        else if (r11 >= g11 + m11 && r11 >= b11 + m11)
            return COL_RED;
        else if (g11 >= r11 + m11 && g11 >= b11 + m11)
            return COL_GREEN;
        else if (b11 >= r11 + m11 && b11 >= g11 + m11)
            return COL_BLUE;
        else if (total >= white_thresh)
            return COL_WHITE;
        else
            return COL_UNKNOWN;
    endfunction

endpackage

// File: rtl/color_debounce.sv
// Debounces the raw colour code across consecutive samples.
//  clk, reset : clock, synchronous active-high reset
//  update     : a new raw code is present on raw this cycle
//  flush      : sensor went stale; forget candidate and force UNKNOWN
//  raw        : raw classification of the current sample
//  color      : debounced colour code
//  changed    : one-cycle pulse when color takes a new value
module color_debounce
    import color_classifier_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic       flush,
    input  logic [2:0] raw,
    output logic [2:0] color,
    output logic       changed
);

    localparam int unsigned CW = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_COUNT);

    logic [2:0]    candidate, cand_next;
    logic [CW-1:0] count, count_next;

    always_comb begin
        cand_next  = candidate;
        count_next = count;
        if (raw == candidate) begin
            if (count < STABLE)
                count_next = count + CW'(1);
        end else begin
            cand_next  = raw;
            count_next = CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            candidate <= COL_UNKNOWN;
            count     <= '0;
            color     <= COL_UNKNOWN;
            changed   <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (flush) begin
                candidate <= COL_UNKNOWN;
                count     <= '0;
                color     <= COL_UNKNOWN;
            end else if (update) begin
                candidate <= cand_next;
                count     <= count_next;
                if (count_next == STABLE && cand_next != color) begin
                    color   <= cand_next;
                    changed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/color_classifier.sv
// Classifies RGB pulse-count triplets into colour codes, debounces them
// and flags a stale sensor.
//  clk, reset    : clock, synchronous active-high reset
//  rgb_valid     : one-cycle strobe, red/green/blue hold a new triplet
//  red/green/blue: 10-bit filter pulse counts (10'h3FF means underflow -> 0)
//  color         : debounced colour code (COL_*)
//  color_valid   : one-cycle pulse, a sample finished classification
//  color_changed : one-cycle pulse with color_valid when color changed
//  stale         : high while no rgb_valid for TIMEOUT_CYCLES
//  overrun       : one-cycle pulse, strobe arrived while busy and was dropped
module color_classifier
    import color_classifier_pkg::*;
#(
    parameter logic [11:0] DARK_THRESH    = 12'd60,
    parameter logic [11:0] WHITE_THRESH   = 12'd900,
    parameter logic [9:0]  DOM_MARGIN     = 10'd40,
    parameter int unsigned STABLE_COUNT   = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rgb_valid,
    input  logic [9:0] red,
    input  logic [9:0] green,
    input  logic [9:0] blue,
    output logic [2:0] color,
    output logic       color_valid,
    output logic       color_changed,
    output logic       stale,
    output logic       overrun
);

    cc_state_t state, state_next;

    logic        accept;
    logic        timeout_hit;
    logic [9:0]  in_r, in_g, in_b;
    logic [9:0]  r_q, g_q, b_q;
    logic [11:0] total;
    logic [2:0]  raw_code;
    logic [31:0] timer;

    assign accept = (state == ST_IDLE) && rgb_valid;

    // Fires on the single cycle the timer steps onto TIMEOUT_CYCLES.
    assign timeout_hit = !accept && (timer == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (rgb_valid) state_next = ST_LATCH;
            ST_LATCH:    state_next = ST_SUM;
            ST_SUM:      state_next = ST_CLASSIFY;
            ST_CLASSIFY: state_next = ST_UPDATE;
            ST_UPDATE:   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Inputs are captured on the accepting edge since they are only
    // guaranteed during the strobe; the underflow mapping is applied in LATCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_r        <= '0;
            in_g        <= '0;
            in_b        <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            total       <= '0;
            raw_code    <= COL_UNKNOWN;
            color_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            color_valid <= (state == ST_UPDATE);
            overrun     <= rgb_valid && (state != ST_IDLE);
            if (accept) begin
                in_r <= red;
                in_g <= green;
                in_b <= blue;
            end
            if (state == ST_LATCH) begin
                r_q <= (in_r == 10'h3FF) ? 10'd0 : in_r;
                g_q <= (in_g == 10'h3FF) ? 10'd0 : in_g;
                b_q <= (in_b == 10'h3FF) ? 10'd0 : in_b;
            end
            if (state == ST_SUM)
                total <= {2'b00, r_q} + {2'b00, g_q} + {2'b00, b_q};
            if (state == ST_CLASSIFY)
                raw_code <= classify(r_q, g_q, b_q, total,
                                     DARK_THRESH, WHITE_THRESH, DOM_MARGIN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            stale <= 1'b0;
        end else if (accept) begin
            timer <= '0;
            stale <= 1'b0;
        end else if (timer != TIMEOUT_CYCLES) begin
            timer <= timer + 32'd1;
            if (timeout_hit)
                stale <= 1'b1;
        end
    end

    color_debounce #(
        .STABLE_COUNT (STABLE_COUNT)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .update  (state == ST_UPDATE),
        .flush   (timeout_hit),
        .raw     (raw_code),
        .color   (color),
        .changed (color_changed)
    );

endmodule

// File: tb/tb_color_classifier.sv
// Directed self-checking bench for color_classifier (TIMEOUT_CYCLES=200).
module tb_color_classifier;

    logic       clk;
    logic       reset;
    logic       rgb_valid;
    logic [9:0] red, green, blue;
    logic [2:0] color;
    logic       color_valid;
    logic       color_changed;
    logic       stale;
    logic       overrun;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cv_count = 0;
    int unsigned ov_count = 0;

    color_classifier #(
        .STABLE_COUNT   (3),
        .TIMEOUT_CYCLES (32'd200)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rgb_valid     (rgb_valid),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .color         (color),
        .color_valid   (color_valid),
        .color_changed (color_changed),
        .stale         (stale),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (color_valid) cv_count++;
        if (overrun)     ov_count++;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed === expected)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    // Strobe one triplet, wait (bounded) for color_valid, check latency and outputs.
    task automatic send_sample(input string tag, input logic [9:0] r,
                               input logic [9:0] g, input logic [9:0] b,
                               input logic [2:0] exp_color, input logic exp_changed);
        int unsigned lat;
        bit found;
        @(negedge clk);
        rgb_valid = 1'b1;
        red = r; green = g; blue = b;
        @(posedge clk);
        #1;
        rgb_valid = 1'b0;
        red = '0; green = '0; blue = '0;
        found = 1'b0;
        lat = 0;
        for (int unsigned i = 1; i <= 8 && !found; i++) begin
            @(posedge clk);
            #1;
            if (color_valid) begin
                found = 1'b1;
                lat = i;
            end
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_color"}, color, exp_color);
        check({tag, "_changed"}, color_changed, exp_changed);
        idle(5);
    endtask

    int unsigned cv0, ov0;

    initial begin
        reset = 1'b1;
        rgb_valid = 1'b0;
        red = '0; green = '0; blue = '0;
        idle(3);
        reset = 1'b0;

        // 1. reset state
        idle(10);
        check("rst_color", color, 0);
        check("rst_valid", color_valid, 0);
        check("rst_changed", color_changed, 0);
        check("rst_stale", stale, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cv_count", cv_count, 0);

        // 2. red debounces on the third sample
        send_sample("red1", 10'd400, 10'd100, 10'd90, 3'd0, 1'b0);
        send_sample("red2", 10'd400, 10'd100, 10'd90, 3'd0, 1'b0);
        send_sample("red3", 10'd400, 10'd100, 10'd90, 3'd1, 1'b1);

        // 3. black, white, then a single unknown that must not change color
        send_sample("blk1", 10'd20, 10'd15, 10'd10, 3'd1, 1'b0);
        send_sample("blk2", 10'd20, 10'd15, 10'd10, 3'd1, 1'b0);
        send_sample("blk3", 10'd20, 10'd15, 10'd10, 3'd5, 1'b1);
        send_sample("wht1", 10'd350, 10'd350, 10'd350, 3'd5, 1'b0);
        send_sample("wht2", 10'd350, 10'd350, 10'd350, 3'd5, 1'b0);
        send_sample("wht3", 10'd350, 10'd350, 10'd350, 3'd4, 1'b1);
        send_sample("unk1", 10'd200, 10'd180, 10'd170, 3'd4, 1'b0);

        // 4. 3FF on red reads as 0, so green dominates
        send_sample("uf1", 10'h3FF, 10'd300, 10'd10, 3'd4, 1'b0);
        send_sample("uf2", 10'h3FF, 10'd300, 10'd10, 3'd4, 1'b0);
        send_sample("uf3", 10'h3FF, 10'd300, 10'd10, 3'd2, 1'b1);

        // 5. strobe on two consecutive clocks: second one dropped
        cv0 = cv_count;
        ov0 = ov_count;
        @(negedge clk);
        rgb_valid = 1'b1;
        red = 10'd10; green = 10'd300; blue = 10'd10;
        @(negedge clk);
        red = 10'd400; green = 10'd10; blue = 10'd10;
        @(negedge clk);
        rgb_valid = 1'b0;
        idle(10);
        check("b2b_cv", cv_count - cv0, 1);
        check("b2b_ov", ov_count - ov0, 1);
        check("b2b_color", color, 2);

        // 6. stale after 200 idle clocks from the last accepted strobe
        send_sample("pre_stale", 10'd10, 10'd300, 10'd10, 3'd2, 1'b0);
        idle(185);
        check("stale_early", stale, 0);
        idle(10);
        check("stale_set", stale, 1);
        check("stale_color", color, 0);
        @(negedge clk);
        rgb_valid = 1'b1;
        red = 10'd10; green = 10'd300; blue = 10'd10;
        @(negedge clk);
        rgb_valid = 1'b0;
        check("stale_clr_latch", stale, 0);
        idle(8);
        check("post_stale_color", color, 0);

        // reset asserted while the sample sits in SUM
        cv0 = cv_count;
        @(negedge clk);
        rgb_valid = 1'b1;
        red = 10'd400; green = 10'd10; blue = 10'd10;
        @(posedge clk);
        #1;
        rgb_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(10);
        check("midrst_cv", cv_count - cv0, 0);
        check("midrst_color", color, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
